// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 16x oversampling: synchronizes the line, deframes one
// character at a time and reports either a data strobe or a framing error.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done,
    output logic            o_frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [3:0]    S_MID  = 4'd7;
    localparam logic [3:0]    S_LAST = 4'd15;
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

    state_e          state_q, state_d;
    logic            rxMeta_q, rx_q;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    // Synchronizer resets high so a released reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rxMeta_q <= 1'b1;
            rx_q     <= 1'b1;
            state_q  <= IDLE;
            s_q      <= '0;
            n_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rxMeta_q <= i_rx;
            rx_q     <= rxMeta_q;
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx_q ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_q == S_STOP) begin
                        s_d     = '0;
                        state_d = rx_q ? IDLE : BRK;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            BRK: begin
                if (rx_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes fire on the final stop tick and are registered, so they appear one cycle later.
    always_comb begin
        done_d = 1'b0;
        ferr_d = 1'b0;
        data_d = data_q;
        if (state_q == STOP && i_tick && s_q == S_STOP) begin
            if (rx_q) begin
                done_d = 1'b1;
                data_d = b_q;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

endmodule
